// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: op encodings, FSM states
// and iteration/divide-by-zero constants.
package muldiv_pkg;
  localparam int WIDTH = 32;
  localparam int ITER_COUNT = 32;
  localparam logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;
endpackage

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU on magnitudes, with HI/LO and MTHI/MTLO; 33 cycles Start edge to result edge.
// No queueing: Start and moves are ignored while Busy, upstream stalls on Busy; Flush aborts without writing.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] MoveData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);

  localparam logic [5:0] LAST_ITER = 6'(ITER_COUNT - 1);

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] sign_fix(input logic [2*WIDTH-1:0] r, input logic is_div,
                                                  input logic neg_q, input logic neg_r,
                                                  input logic div0);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rm;
    if (!is_div) return neg_q ? -r : r;
    q  = neg_q ? -r[WIDTH-1:0] : r[WIDTH-1:0];
    rm = neg_r ? -r[2*WIDTH-1:WIDTH] : r[2*WIDTH-1:WIDTH];
    // The magnitude divide already leaves |dividend| as remainder; only LO needs forcing.
    if (div0) q = DIV0_LO;
    return {rm, q};
  endfunction

  state_e             state;
  op_e                op_q;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [5:0]         cnt;
  logic               neg_q, neg_r, div0;
  logic               op_is_div, in_signed, in_div;
  logic [WIDTH:0]     sum, prem;
  logic [WIDTH-1:0]   diff;
  logic               fits;

  assign op_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign in_signed = (op_e'(Op) == OP_MULT) || (op_e'(Op) == OP_DIV);
  assign in_div    = (op_e'(Op) == OP_DIV) || (op_e'(Op) == OP_DIVU);
  assign Busy      = (state != IDLE);

  // acc holds {product hi, multiplier} for multiply, {remainder, dividend->quotient} for divide.
  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};
    prem = acc[2*WIDTH-1:WIDTH-1];
    fits = (prem >= {1'b0, mcand});
    diff = WIDTH'(prem - {1'b0, mcand});
    if (op_is_div)
      acc_next = fits ? {diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
    else
      acc_next = {sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      op_q  <= OP_MULT;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
      Hi    <= '0;
      Lo    <= '0;
      Done  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (HiWrite) Hi <= MoveData;
          if (LoWrite) Lo <= MoveData;
          if (Start && !Flush) begin
            op_q  <= op_e'(Op);
            cnt   <= '0;
            neg_q <= in_signed && (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
            neg_r <= in_signed && in_div && OperandA[WIDTH-1];
            div0  <= in_div && (OperandB == '0);
            if (in_div) begin
              mcand <= mag(OperandB, in_signed);
              acc   <= {{WIDTH{1'b0}}, mag(OperandA, in_signed)};
            end else begin
              mcand <= mag(OperandA, in_signed);
              acc   <= {{WIDTH{1'b0}}, mag(OperandB, in_signed)};
            end
            state <= RUN;
          end
        end
        RUN: begin
          if (Flush) begin
            state <= IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 6'd1;
            if (cnt == LAST_ITER) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!Flush) begin
            {Hi, Lo} <= sign_fix(acc, op_is_div, neg_q, neg_r, div0);
            Done     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized bench for mul_div_unit against a cycle-count/arithmetic reference model,
// plus directed literal expectations.
module tb_mul_div_unit;
  import muldiv_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, Start, Flush, HiWrite, LoWrite;
  logic [1:0]  Op;
  logic [31:0] OperandA, OperandB, MoveData;
  logic [31:0] Hi, Lo;
  logic        Busy, Done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mul_div_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB), .Flush(Flush),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .MoveData(MoveData),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Architectural result: {HI, LO}.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    logic [63:0] q, r, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      default: begin
        if (b == 32'b0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          q = 64'(sa / sb);
          r = 64'(sa % sb);
        end else begin
          q = ua / ub;
          r = ua % ub;
        end
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  logic        m_busy, m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_left;

  always @(posedge Clk) begin
    m_done <= 1'b0;
    if (!Reset) begin
      m_busy <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
    end else if (m_busy) begin
      if (Flush) m_busy <= 1'b0;
      else if (m_left == 1) begin
        m_busy       <= 1'b0;
        {m_hi, m_lo} <= m_res;
        m_done       <= 1'b1;
      end else m_left <= m_left - 1;
    end else begin
      if (HiWrite) m_hi <= MoveData;
      if (LoWrite) m_lo <= MoveData;
      if (Start && !Flush) begin
        m_busy <= 1'b1;
        m_left <= 33;
        m_res  <= ref_result(Op, OperandA, OperandB);
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      checks++;
      if (Hi !== m_hi || Lo !== m_lo || Busy !== m_busy || Done !== m_done) begin
        errors++;
        $display("FAIL model_cmp t=%0t actual hi=%h lo=%h busy=%b done=%b required hi=%h lo=%h busy=%b done=%b",
                 $time, Hi, Lo, Busy, Done, m_hi, m_lo, m_busy, m_done);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge. mode 0 normal, 1 disturb during RUN, 2 flush at E10, 3 reset at E20.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int mode, output int lat);
    Op = op; OperandA = a; OperandB = b; Start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      if (Done && lat < 0) lat = k;
      if (k == 1) begin
        Start = 1'b0; OperandA = $urandom; OperandB = $urandom; Op = 2'($urandom);
      end
      case (mode)
        1: begin
          if (k == 5) begin Start = 1'b1; Op = OP_DIVU; OperandA = 100; OperandB = 7; end
          if (k == 6) Start = 1'b0;
          if (k == 8) begin HiWrite = 1'b1; MoveData = 32'hDEAD; end
          if (k == 9) HiWrite = 1'b0;
        end
        2: begin
          if (k == 10) Flush = 1'b1;
          if (k == 11) begin Flush = 1'b0; chk("flush_busy", {31'b0, Busy}, 32'd0); end
        end
        3: begin
          if (k == 20) Reset = 1'b0;
          if (k == 21) begin
            Reset = 1'b1;
            chk("rst_hi", Hi, 32'd0);
            chk("rst_lo", Lo, 32'd0);
            chk("rst_busy", {31'b0, Busy}, 32'd0);
            chk("rst_done", {31'b0, Done}, 32'd0);
          end
        end
        default: ;
      endcase
      if (lat > 0 && mode < 2) break;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 7)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  int lat;

  initial begin
    Reset = 1'b0; Start = 1'b0; Flush = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    Op = 2'b00; OperandA = '0; OperandB = '0; MoveData = '0;
    repeat (3) @(negedge Clk);
    chk_en = 1'b1;
    chk("reset_hi", Hi, 32'd0);
    chk("reset_lo", Lo, 32'd0);
    chk("reset_busy", {31'b0, Busy}, 32'd0);
    chk("reset_done", {31'b0, Done}, 32'd0);
    Reset = 1'b1;
    @(negedge Clk);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat);
    chk("multu_latency", lat, 34);
    chk("multu_hi", Hi, 32'hFFFF_FFFE);
    chk("multu_lo", Lo, 32'h0000_0001);
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'h7, 0, lat);
    chk("mult_neg_hi", Hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", Lo, 32'hFFFF_FFEB);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, lat);
    chk("mult_min_hi", Hi, 32'h4000_0000);
    chk("mult_min_lo", Lo, 32'h0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, 0, lat);
    chk("div_neg_lo", Lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", Hi, 32'hFFFF_FFFF);
    chk("div_latency", lat, 34);
    run_op(OP_DIVU, 32'h7, 32'h0, 0, lat);
    chk("divu0_hi", Hi, 32'h7);
    chk("divu0_lo", Lo, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0, 0, lat);
    chk("div0_hi", Hi, 32'hFFFF_FFF9);
    chk("div0_lo", Lo, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat);
    chk("div_ovf_lo", Lo, 32'h8000_0000);
    chk("div_ovf_hi", Hi, 32'h0);

    HiWrite = 1'b1; MoveData = 32'h1234;
    @(negedge Clk);
    HiWrite = 1'b0;
    chk("mthi", Hi, 32'h1234);
    run_op(OP_MULTU, 32'd3, 32'd5, 1, lat);
    chk("busy_ign_hi", Hi, 32'h0);
    chk("busy_ign_lo", Lo, 32'd15);
    chk("busy_ign_latency", lat, 34);

    run_op(OP_DIVU, 32'd1000, 32'd3, 2, lat);
    chk("flush_no_done", lat, -1);
    chk("flush_hi", Hi, 32'h0);
    chk("flush_lo", Lo, 32'd15);
    Start = 1'b1; Flush = 1'b1; Op = OP_MULTU;
    @(negedge Clk);
    Start = 1'b0; Flush = 1'b0;
    chk("start_flush_idle", {31'b0, Busy}, 32'd0);

    run_op(OP_MULTU, 32'd9, 32'd9, 3, lat);
    chk("reset_mid_no_done", lat, -1);
    run_op(OP_MULTU, 32'd2, 32'd2, 0, lat);
    chk("after_rst_lo", Lo, 32'd4);
    chk("after_rst_latency", lat, 34);

    for (int i = 0; i < 4000; i++) begin
      @(negedge Clk);
      Start    = ($urandom % 4 == 0);
      Op       = 2'($urandom);
      OperandA = pick();
      OperandB = pick();
      Flush    = ($urandom % 150 == 0);
      HiWrite  = ($urandom % 12 == 0);
      LoWrite  = ($urandom % 12 == 0);
      MoveData = $urandom;
      Reset    = ($urandom % 800 != 0);
    end
    @(negedge Clk);
    Start = 1'b0; Flush = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0; Reset = 1'b1;
    repeat (40) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
